// File: rtl/uart_pkg.sv
// Shared UART register-bus definitions: feeder state encoding and register addresses.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] UART_ADDR_CTRL = 3'd0;
  localparam logic [ADDR_W-1:0] UART_ADDR_RX   = 3'd1;
  localparam logic [ADDR_W-1:0] UART_ADDR_TX   = 3'd2;

  typedef enum logic [2:0] {
    FdIdle,
    FdPollAddr,
    FdPollSample,
    FdPollWait,
    FdLoad,
    FdWrite,
    FdRelease
  } FeederState;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead head, registered full/empty flags and occupancy count.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [BYTE_W-1:0]       wdata,
  output logic [BYTE_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [CW-1:0]     count_next;

  always_comb begin
    push_ok    = push & ~full;
    pop_ok     = pop & ~empty;
    count_next = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and writes each one to the UART Tx register once a
// control-register poll reports the transmitter free.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TX_BUSY_BIT = 0,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [BYTE_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    uart_cs,
  output logic                    uart_rd,
  output logic                    uart_wr,
  output logic [ADDR_W-1:0]       uart_addr,
  output logic [BYTE_W-1:0]       uart_in_data,
  input  logic [BYTE_W-1:0]       uart_out_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned GW       = $clog2(POLL_GAP) + 1;
  localparam logic [2:0]  BUSY_IDX = 3'(TX_BUSY_BIT);

  FeederState        state;
  FeederState        state_d;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_d;

  logic              push_en;
  logic              pop_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata;
  logic [CW-1:0]     count_next;

  logic              cs_d;
  logic              rd_d;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BYTE_W-1:0] data_d;
  logic              in_ready_d;
  logic              busy_d;

  // Only the busy bit of the control register is meaningful here.
  logic              unused_ctrl_bits;
  assign unused_ctrl_bits = ^uart_out_data;

  assign push_en = in_valid & in_ready & ~fifo_full;
  assign pop_en  = (state == FdWrite);

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_en),
    .pop   (pop_en),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next state, then bus values decoded from the next state so they register in step.
  always_comb begin
    state_d    = state;
    gap_d      = gap_cnt;
    cs_d       = 1'b1;
    rd_d       = 1'b1;
    wr_d       = 1'b1;
    addr_d     = uart_addr;
    data_d     = uart_in_data;
    count_next = fifo_count + CW'(push_en) - CW'(pop_en);
    in_ready_d = (count_next != CW'(DEPTH));

    case (state)
      FdIdle: begin
        if (!fifo_empty) begin
          state_d = FdPollAddr;
        end
      end
      FdPollAddr:   state_d = FdPollSample;
      FdPollSample: begin
        if (uart_out_data[BUSY_IDX]) begin
          state_d = FdPollWait;
          gap_d   = GW'(POLL_GAP - 1);
        end else begin
          state_d = FdLoad;
        end
      end
      FdPollWait: begin
        if (gap_cnt == '0) begin
          state_d = FdPollAddr;
        end else begin
          gap_d = gap_cnt - GW'(1);
        end
      end
      FdLoad:    state_d = FdWrite;
      FdWrite:   state_d = FdRelease;
      FdRelease: state_d = FdIdle;
      default:   state_d = FdIdle;
    endcase

    case (state_d)
      FdPollAddr, FdPollSample: begin
        cs_d   = 1'b0;
        rd_d   = 1'b0;
        addr_d = UART_ADDR_CTRL;
      end
      FdLoad: begin
        cs_d   = 1'b0;
        addr_d = UART_ADDR_TX;
        data_d = fifo_rdata;
      end
      FdWrite: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
      end
      default: ;
    endcase

    busy_d = (count_next != '0) | (state_d != FdIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FdIdle;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_d;
    end
  end

  // Registered bus and status outputs; reset forces every strobe inactive at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uart_cs      <= 1'b1;
      uart_rd      <= 1'b1;
      uart_wr      <= 1'b1;
      uart_addr    <= UART_ADDR_CTRL;
      uart_in_data <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      uart_cs      <= cs_d;
      uart_rd      <= rd_d;
      uart_wr      <= wr_d;
      uart_addr    <= addr_d;
      uart_in_data <= data_d;
      in_ready     <= in_ready_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte-stream front end that sits directly upstream of UART_Component and drives its register bus (cs/rd/wr/addr/in_data).
- Producers push bytes over a valid/ready port. The feeder buffers them in a small FIFO.
- For each byte it polls the UART control register until the transmitter is free, then writes the byte to the Tx buffer (addr 2).
- Replaces hand-written per-byte write sequences in top-level state machines.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, minimum 2.
TX_BUSY_BIT, 0, bit index of "transmitter busy" in control register (addr 0); 1 = busy.
POLL_GAP, 4, idle cycles between consecutive control-register polls while busy; minimum 1.

Ports:
clock  in  1  system clock (48 MHz)
reset  in  1  asynchronous, active-high reset
in_valid  in  1  producer has a byte
in_data  in  8  byte to transmit
in_ready  out  1  feeder can accept a byte (FIFO not full)
uart_cs  out  1  UART chip select, active low
uart_rd  out  1  UART read strobe, active low
uart_wr  out  1  UART write strobe, active low
uart_addr  out  3  UART register address (0 control, 2 Tx buffer)
uart_in_data  out  8  byte driven to UART Tx buffer
uart_out_data  in  8  UART read data (control register during polls)
fifo_count  out  $clog2(DEPTH)+1  bytes currently buffered
busy  out  1  FIFO non-empty or transaction in flight

Behaviour:
- Reset (async, active-high):
  - uart_cs = uart_rd = uart_wr = 1; uart_addr = 0; uart_in_data = 0.
  - FIFO emptied; fifo_count = 0; busy = 0; state = FdIdle.
  - in_ready = 0 while reset is asserted, 1 from the first clock after release.
  - Reset mid-transaction aborts it; no partial strobe is held.
- Push: in_valid & in_ready at a rising edge stores in_data. Full → in_ready = 0 and the byte is not taken.
- Simultaneous push and pop in one cycle is legal: fifo_count is unchanged and data order is preserved. Push on full is dropped only because in_ready = 0.
- All UART bus outputs are registered; no combinational path from in_* to uart_*.
- FSM (states in the shared enum):
  - FdIdle: strobes high. FIFO non-empty → FdPollAddr.
  - FdPollAddr: uart_addr = 0, uart_cs = 0, uart_rd = 0 → FdPollSample.
  - FdPollSample: cs/rd still low; capture uart_out_data at the end of this cycle. Read data is valid on the second cycle of the strobe.
    - Bit TX_BUSY_BIT = 1 → FdPollWait.
    - Bit = 0 → FdLoad.
  - FdPollWait: strobes high for POLL_GAP cycles (counter), then → FdPollAddr.
  - FdLoad: uart_addr = 2, uart_in_data = FIFO head, uart_cs = 0, uart_wr = 1 (setup cycle) → FdWrite.
  - FdWrite: uart_cs = 0, uart_wr = 0 for exactly one cycle; FIFO pops at the end of this cycle → FdRelease.
  - FdRelease: uart_cs = uart_wr = 1; addr and data held → FdIdle.
- Minimum per-byte latency when the UART is idle: 5 cycles from FdIdle leaving to the next FdIdle (PollAddr, PollSample, Load, Write, Release).
- Every byte is preceded by at least one poll; back-to-back writes without a poll never occur.
- uart_rd and uart_wr are never low in the same cycle. uart_wr is low only while uart_cs is low and uart_addr = 2.
- busy = (fifo_count != 0) | (state != FdIdle).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count saturates logically at DEPTH and never exceeds it.
- No polling timeout: a permanently busy UART stalls the feeder indefinitely, with in_ready governed by FIFO space only.

Decomposition:
- Shared package uart_pkg:
  - FeederState enum (FdIdle, FdPollAddr, FdPollSample, FdPollWait, FdLoad, FdWrite, FdRelease).
  - Address constants UART_ADDR_CTRL = 3'd0, UART_ADDR_RX = 3'd1, UART_ADDR_TX = 3'd2.
- One sub-module: byte_fifo (synchronous, parameter DEPTH, async active-high reset). Ports: push/pop/wdata/rdata(head, show-ahead)/full/empty/count.

Test Plan:
- Single byte, UART idle: push 8'h4F at cycle 0 (control register returns 8'h00) → exactly one write with addr = 2, data = 8'h4F, wr low 1 cycle; busy returns to 0 by cycle 7.
- Busy UART: control returns bit0 = 1 for 3 polls, then 0; push 8'h41 → 4 read transactions spaced POLL_GAP = 4 idle cycles apart, then one write of 8'h41; no write before the 4th poll.
- Burst and full: push 20 bytes 8'h00–8'h13 back-to-back with the UART held busy → in_ready drops after 16 accepted bytes and fifo_count = 16. Release busy → writes 8'h00–8'h0F in order; in_ready reasserts after the first pop.
- Concurrent push/pop: push a new byte on the same cycle as a FdWrite pop with fifo_count = 3 → fifo_count stays 3; output order is intact.
- Reset mid-write: assert reset during FdLoad → cs/rd/wr go high asynchronously in the same cycle; fifo_count = 0; after release no write is issued until a new push.
- Bus protocol checker (runs across all tests): rd & wr never both low; wr low implies cs low and addr = 2; each write is preceded by at least one completed poll.
